ip_frame_dispatcher: RTL and testbench

//  Upstream frame scheduler for an array of IP_AMT image_processor instances. Accepts one AXI-Stream
//  of 256-bit pixel groups, assigns each whole frame (tlast-delimited) to one idle processor,

---
 rtl/ip_dispatch_pkg.sv | 15 +
 rtl/rr_arbiter.sv | 36 +++
 rtl/ip_frame_dispatcher.sv | 141 ++++++++++++++
 tb/tb_ip_frame_dispatcher.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ip_dispatch_pkg.sv
// Shared FSM encoding, default frame length and width helper for the IP frame dispatcher.
package ip_dispatch_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } state_t;

  localparam int FRAME_BEATS_DEF = 2400;

  function automatic int max1(input int w);
    return (w > 1) ? w : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin first-free search: returns the nearest free processor index at or after rr_ptr.
module rr_arbiter
  import ip_dispatch_pkg::*;
#(
  parameter int IP_AMT = 4,
  parameter int IDX_W  = max1($clog2(IP_AMT))
) (
  input  logic [IP_AMT-1:0] free,
  input  logic [IDX_W-1:0]  rr_ptr,
  output logic [IDX_W-1:0]  idx,
  output logic              found
);

  logic [2*IP_AMT-1:0] doubled;
  logic [IP_AMT-1:0]   rotated;
  int                  pos;

  // Rotating the free mask puts rr_ptr at bit 0, so the lowest set bit is the winner.
  assign doubled = {free, free} >> rr_ptr;
  assign rotated = doubled[IP_AMT-1:0];

  always_comb begin
    found = 1'b0;
    pos   = 0;
    for (int i = IP_AMT - 1; i >= 0; i--) begin
      if (rotated[i]) begin
        found = 1'b1;
        pos   = i;
      end
    end
    pos = pos + int'(rr_ptr);
    if (pos >= IP_AMT) pos = pos - IP_AMT;
    idx = IDX_W'(pos);
  end

endmodule

// File: rtl/ip_frame_dispatcher.sv
// Dispatches tlast-delimited AXIS frames round-robin to idle image processors.
// Optional frame-length checking is enabled by defining FRAME_BEAT_CHECK_EN.
module ip_frame_dispatcher
  import ip_dispatch_pkg::*;
#(
  parameter int  IP_AMT       = 4,
  parameter int  IP_ADDR_W    = $clog2(IP_AMT),
  parameter int  AXIS_TID_W   = 2,
  parameter int  AXIS_TDATA_W = 256,
  parameter int  FRAME_BEATS  = FRAME_BEATS_DEF,
  parameter int  CNT_W        = 16,
  localparam int IDX_W        = max1(IP_ADDR_W),
  localparam int KEEP_W       = AXIS_TDATA_W / 8
) (
  input  logic                    s_aclk,
  input  logic                    s_aresetn,
  input  logic [AXIS_TID_W-1:0]   s_tid_i,
  input  logic [AXIS_TDATA_W-1:0] s_tdata_i,
  input  logic [KEEP_W-1:0]       s_tkeep_i,
  input  logic [KEEP_W-1:0]       s_tstrb_i,
  input  logic                    s_tlast_i,
  input  logic                    s_tvalid_i,
  output logic                    s_tready_o,
  output logic [AXIS_TID_W-1:0]   m_tid_o,
  output logic [AXIS_TDATA_W-1:0] m_tdata_o,
  output logic [KEEP_W-1:0]       m_tkeep_o,
  output logic [KEEP_W-1:0]       m_tstrb_o,
  output logic                    m_tlast_o,
  output logic [IDX_W-1:0]        m_tdest_o,
  output logic [IP_AMT-1:0]       m_tvalid_o,
  input  logic [IP_AMT-1:0]       m_tready_i,
  input  logic [IP_AMT-1:0]       ip_done_i,
  output logic [IP_AMT-1:0]       ip_busy_o,
  output logic [CNT_W-1:0]        frame_cnt_o,
  output logic                    err_o
);

  state_t            state;
  logic [IDX_W-1:0]  grant;
  logic [IDX_W-1:0]  rr_ptr;
  logic [IDX_W-1:0]  arb_idx;
  logic              arb_found;
  logic [IP_AMT-1:0] free_mask;
  logic [IP_AMT-1:0] grant_oh;
  logic [IP_AMT-1:0] done_mask;
  logic [IP_AMT-1:0] busy_next;
  logic              in_stream;
  logic              handshake;
  logic              frame_end;

  assign free_mask = ~ip_busy_o;

  rr_arbiter #(
    .IP_AMT (IP_AMT),
    .IDX_W  (IDX_W)
  ) u_rr_arbiter (
    .free   (free_mask),
    .rr_ptr (rr_ptr),
    .idx    (arb_idx),
    .found  (arb_found)
  );

  assign in_stream  = (state == ST_STREAM);
  assign grant_oh   = IP_AMT'(1) << grant;
  assign s_tready_o = in_stream && |(m_tready_i & grant_oh);
  assign m_tvalid_o = (in_stream && s_tvalid_i) ? grant_oh : '0;
  assign m_tdest_o  = grant;
  assign handshake  = s_tvalid_i && s_tready_o;

  assign m_tid_o   = s_tid_i;
  assign m_tdata_o = s_tdata_i;
  assign m_tkeep_o = s_tkeep_i;
  assign m_tstrb_o = s_tstrb_i;

  // A done pulse for the processor currently being fed is dropped: its frame is still arriving.
  assign done_mask = ip_done_i & ~(in_stream ? grant_oh : '0);

  always_comb begin
    busy_next = ip_busy_o & ~done_mask;
    if (!in_stream && s_tvalid_i && arb_found)
      busy_next = busy_next | (IP_AMT'(1) << arb_idx);
  end

`ifdef FRAME_BEAT_CHECK_EN
  localparam int BEAT_W = max1($clog2(FRAME_BEATS));

  logic [BEAT_W-1:0] beat_cnt;
  logic              force_last;

  assign force_last = in_stream && (beat_cnt == BEAT_W'(FRAME_BEATS - 1));
  assign m_tlast_o  = s_tlast_i || force_last;
  assign frame_end  = handshake && m_tlast_o;

  // Early tlast and overlong frames both flag an error; overlong frames are cut at the limit.
  always_ff @(posedge s_aclk or negedge s_aresetn) begin
    if (!s_aresetn) begin
      beat_cnt <= '0;
      err_o    <= 1'b0;
    end else begin
      err_o <= handshake && (s_tlast_i != force_last);
      if (!in_stream)
        beat_cnt <= '0;
      else if (handshake)
        beat_cnt <= beat_cnt + BEAT_W'(1);
    end
  end
`else
  assign m_tlast_o = s_tlast_i;
  assign frame_end = handshake && s_tlast_i;
  assign err_o     = 1'b0;
`endif

  always_ff @(posedge s_aclk or negedge s_aresetn) begin
    if (!s_aresetn) begin
      state       <= ST_IDLE;
      grant       <= '0;
      rr_ptr      <= '0;
      ip_busy_o   <= '0;
      frame_cnt_o <= '0;
    end else begin
      ip_busy_o <= busy_next;
      case (state)
        ST_IDLE: begin
          if (s_tvalid_i && arb_found) begin
            grant <= arb_idx;
            state <= ST_STREAM;
          end
        end
        ST_STREAM: begin
          if (frame_end) begin
            frame_cnt_o <= frame_cnt_o + CNT_W'(1);
            rr_ptr      <= (grant == IDX_W'(IP_AMT - 1)) ? '0 : grant + IDX_W'(1);
            state       <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ip_frame_dispatcher.sv
// Scoreboard bench for ip_frame_dispatcher; the frame-length scenario runs when FRAME_BEAT_CHECK_EN is defined.
module tb_ip_frame_dispatcher;

  localparam int IP_AMT = 4;
`ifdef FRAME_BEAT_CHECK_EN
  localparam int TB_FB = 4;
`else
  localparam int TB_FB = 2400;
`endif

  typedef struct packed {
    logic [1:0]  dest;
    logic [31:0] data;
    logic        last;
  } beat_t;

  logic               s_aclk = 1'b0;
  logic               s_aresetn;
  logic [1:0]         s_tid_i;
  logic [255:0]       s_tdata_i;
  logic [31:0]        s_tkeep_i;
  logic [31:0]        s_tstrb_i;
  logic               s_tlast_i;
  logic               s_tvalid_i;
  logic               s_tready_o;
  logic [1:0]         m_tid_o;
  logic [255:0]       m_tdata_o;
  logic [31:0]        m_tkeep_o;
  logic [31:0]        m_tstrb_o;
  logic               m_tlast_o;
  logic [1:0]         m_tdest_o;
  logic [IP_AMT-1:0]  m_tvalid_o;
  logic [IP_AMT-1:0]  m_tready_i;
  logic [IP_AMT-1:0]  ip_done_i;
  logic [IP_AMT-1:0]  ip_busy_o;
  logic [15:0]        frame_cnt_o;
  logic               err_o;

  beat_t sb[$];
  int    vectors = 0;
  int    miscompares = 0;
  int    err_seen = 0;

  ip_frame_dispatcher #(
    .IP_AMT       (IP_AMT),
    .AXIS_TID_W   (2),
    .AXIS_TDATA_W (256),
    .FRAME_BEATS  (TB_FB),
    .CNT_W        (16)
  ) dut (
    .s_aclk      (s_aclk),
    .s_aresetn   (s_aresetn),
    .s_tid_i     (s_tid_i),
    .s_tdata_i   (s_tdata_i),
    .s_tkeep_i   (s_tkeep_i),
    .s_tstrb_i   (s_tstrb_i),
    .s_tlast_i   (s_tlast_i),
    .s_tvalid_i  (s_tvalid_i),
    .s_tready_o  (s_tready_o),
    .m_tid_o     (m_tid_o),
    .m_tdata_o   (m_tdata_o),
    .m_tkeep_o   (m_tkeep_o),
    .m_tstrb_o   (m_tstrb_o),
    .m_tlast_o   (m_tlast_o),
    .m_tdest_o   (m_tdest_o),
    .m_tvalid_o  (m_tvalid_o),
    .m_tready_i  (m_tready_i),
    .ip_done_i   (ip_done_i),
    .ip_busy_o   (ip_busy_o),
    .frame_cnt_o (frame_cnt_o),
    .err_o       (err_o)
  );

  always #5 s_aclk = ~s_aclk;

  always @(negedge s_aclk) if (err_o === 1'b1) err_seen = err_seen + 1;

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Pushes the expected beat, then pops and compares it when the DUT accepts it.
  task automatic drive_beat(input logic [31:0] data, input logic last_in,
                            input logic last_exp, input logic [1:0] dest);
    beat_t want;
    bit    accepted = 1'b0;
    sb.push_back('{dest, data, last_exp});
    s_tvalid_i = 1'b1;
    s_tdata_i  = {224'd0, data};
    s_tid_i    = data[1:0];
    s_tlast_i  = last_in;
    for (int c = 0; c < 100 && !accepted; c++) begin
      @(negedge s_aclk);
      if (s_tready_o === 1'b1) begin
        accepted = 1'b1;
        want = sb.pop_front();
        vectors++;
        if (m_tdest_o !== want.dest || m_tdata_o[31:0] !== want.data || m_tlast_o !== want.last ||
            m_tvalid_o !== (4'b0001 << want.dest) || m_tid_o !== want.data[1:0] ||
            m_tkeep_o !== 32'hFFFF_FFFF || m_tstrb_o !== 32'hFFFF_FFFF) begin
          miscompares++;
          $display("[TB] FAIL beat %0h: got dest=%0d valid=%b last=%b data=%0h, expected dest=%0d last=%b data=%0h",
                   data, m_tdest_o, m_tvalid_o, m_tlast_o, m_tdata_o[31:0], want.dest, want.last, want.data);
        end
      end
      @(posedge s_aclk);
      #1;
    end
    if (!accepted) begin
      vectors++;
      miscompares++;
      void'(sb.pop_back());
      $display("[TB] FAIL beat_timeout %0h: not accepted in 100 cycles, expected acceptance", data);
    end
  endtask

  task automatic drive_frame(input int n, input int tag, input logic [1:0] dest);
    for (int b = 0; b < n; b++)
      drive_beat(32'(tag * 16 + b), b == n - 1, b == n - 1, dest);
    s_tvalid_i = 1'b0;
    s_tlast_i  = 1'b0;
  endtask

  task automatic pulse_done(input logic [IP_AMT-1:0] mask);
    ip_done_i = mask;
    @(posedge s_aclk);
    #1;
    ip_done_i = '0;
  endtask

  task automatic test_reset;
    s_aresetn = 1'b0;
    s_tid_i = '0; s_tdata_i = '0; s_tkeep_i = '1; s_tstrb_i = '1;
    s_tlast_i = 1'b0; s_tvalid_i = 1'b0; m_tready_i = '1; ip_done_i = '0;
    repeat (3) @(negedge s_aclk);
    vectors++; if (s_tready_o !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_tready: got %b, expected 0", s_tready_o); end
    vectors++; if (m_tvalid_o !== 4'b0) begin miscompares++; $display("[TB] FAIL reset_tvalid: got %b, expected 0000", m_tvalid_o); end
    vectors++; if (ip_busy_o !== 4'b0) begin miscompares++; $display("[TB] FAIL reset_busy: got %b, expected 0000", ip_busy_o); end
    vectors++; if (frame_cnt_o !== 16'd0) begin miscompares++; $display("[TB] FAIL reset_cnt: got %0d, expected 0", frame_cnt_o); end
    vectors++; if (err_o !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_err: got %b, expected 0", err_o); end
    @(posedge s_aclk);
    #1;
    s_aresetn = 1'b1;
  endtask

  task automatic test_round_robin;
    for (int f = 0; f < 4; f++) drive_frame(3, f + 1, 2'(f));
    @(negedge s_aclk);
    vectors++; if (ip_busy_o !== 4'b1111) begin miscompares++; $display("[TB] FAIL rr_busy: got %b, expected 1111", ip_busy_o); end
    vectors++; if (frame_cnt_o !== 16'd4) begin miscompares++; $display("[TB] FAIL rr_cnt: got %0d, expected 4", frame_cnt_o); end
    @(posedge s_aclk);
    #1;
  endtask

  task automatic test_all_busy;
    s_tvalid_i = 1'b1;
    s_tdata_i  = {224'd0, 32'h50};
    for (int c = 0; c < 5; c++) begin
      @(negedge s_aclk);
      vectors++;
      if (s_tready_o !== 1'b0 || m_tvalid_o !== 4'b0) begin
        miscompares++;
        $display("[TB] FAIL busy_stall: got tready=%b tvalid=%b, expected 0 and 0000", s_tready_o, m_tvalid_o);
      end
    end
    @(posedge s_aclk);
    #1;
    pulse_done(4'b0100);
    @(negedge s_aclk);
    vectors++; if (ip_busy_o !== 4'b1011) begin miscompares++; $display("[TB] FAIL done_clear: got %b, expected 1011", ip_busy_o); end
    drive_frame(3, 5, 2'd2);
    @(negedge s_aclk);
    vectors++; if (ip_busy_o !== 4'b1111) begin miscompares++; $display("[TB] FAIL busy_regrant: got %b, expected 1111", ip_busy_o); end
    vectors++; if (frame_cnt_o !== 16'd5) begin miscompares++; $display("[TB] FAIL busy_cnt: got %0d, expected 5", frame_cnt_o); end
    @(posedge s_aclk);
    #1;
  endtask

  task automatic test_backpressure;
    int seen = 0;
    pulse_done(4'b0001);
    m_tready_i[0] = 1'b0;
    fork
      drive_frame(5, 6, 2'd0);
      for (int c = 0; c < 30; c++) begin
        @(posedge s_aclk);
        #1;
        m_tready_i[0] = ~m_tready_i[0];
      end
      for (int c = 0; c < 31; c++) begin
        @(negedge s_aclk);
        if (|(m_tvalid_o & m_tready_i)) seen++;
      end
    join
    m_tready_i = '1;
    vectors++; if (seen != 5) begin miscompares++; $display("[TB] FAIL bp_beats: got %0d handshakes, expected 5", seen); end
    vectors++; if (frame_cnt_o !== 16'd6) begin miscompares++; $display("[TB] FAIL bp_cnt: got %0d, expected 6", frame_cnt_o); end
    vectors++; if (sb.size() != 0) begin miscompares++; $display("[TB] FAIL bp_sb: got %0d pending, expected 0", sb.size()); end
    @(posedge s_aclk);
    #1;
  endtask

  task automatic test_done_during_stream;
    pulse_done(4'b0010);
    fork
      drive_frame(4, 7, 2'd1);
      begin
        repeat (3) @(posedge s_aclk);
        #1;
        ip_done_i = 4'b0010;
        @(posedge s_aclk);
        #1;
        ip_done_i = '0;
      end
    join
    @(negedge s_aclk);
    vectors++; if (ip_busy_o !== 4'b1111) begin miscompares++; $display("[TB] FAIL done_ignored: got %b, expected 1111", ip_busy_o); end
    vectors++; if (frame_cnt_o !== 16'd7) begin miscompares++; $display("[TB] FAIL done_cnt: got %0d, expected 7", frame_cnt_o); end
    @(posedge s_aclk);
    #1;
  endtask

  task automatic test_reset_mid_frame;
    pulse_done(4'b0100);
    drive_beat(32'h80, 1'b0, 1'b0, 2'd2);
    drive_beat(32'h81, 1'b0, 1'b0, 2'd2);
    s_tvalid_i = 1'b1;
    s_tdata_i  = {224'd0, 32'h82};
    s_aresetn  = 1'b0;
    @(negedge s_aclk);
    vectors++; if (s_tready_o !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_tready: got %b, expected 0", s_tready_o); end
    vectors++; if (m_tvalid_o !== 4'b0) begin miscompares++; $display("[TB] FAIL rst_tvalid: got %b, expected 0000", m_tvalid_o); end
    vectors++; if (ip_busy_o !== 4'b0) begin miscompares++; $display("[TB] FAIL rst_busy: got %b, expected 0000", ip_busy_o); end
    vectors++; if (frame_cnt_o !== 16'd0) begin miscompares++; $display("[TB] FAIL rst_cnt: got %0d, expected 0", frame_cnt_o); end
    s_tvalid_i = 1'b0;
    @(posedge s_aclk);
    #1;
    s_aresetn = 1'b1;
    drive_frame(2, 9, 2'd0);
    @(negedge s_aclk);
    vectors++; if (frame_cnt_o !== 16'd1) begin miscompares++; $display("[TB] FAIL rst_after_cnt: got %0d, expected 1", frame_cnt_o); end
    vectors++; if (ip_busy_o !== 4'b0001) begin miscompares++; $display("[TB] FAIL rst_after_busy: got %b, expected 0001", ip_busy_o); end
    @(posedge s_aclk);
    #1;
  endtask

`ifdef FRAME_BEAT_CHECK_EN
  task automatic test_beat_check;
    int base;
    base = err_seen;
    drive_frame(3, 10, 2'd1);
    repeat (2) @(negedge s_aclk);
    vectors++; if (err_seen - base != 1) begin miscompares++; $display("[TB] FAIL short_err: got %0d pulses, expected 1", err_seen - base); end
    @(posedge s_aclk);
    #1;
    base = err_seen;
    for (int b = 0; b < 4; b++) drive_beat(32'(11 * 16 + b), 1'b0, b == 3, 2'd2);
    drive_beat(32'(11 * 16 + 4), 1'b0, 1'b0, 2'd3);
    drive_beat(32'(11 * 16 + 5), 1'b1, 1'b1, 2'd3);
    s_tvalid_i = 1'b0;
    s_tlast_i  = 1'b0;
    repeat (2) @(negedge s_aclk);
    vectors++; if (err_seen - base != 2) begin miscompares++; $display("[TB] FAIL long_err: got %0d pulses, expected 2", err_seen - base); end
    vectors++; if (frame_cnt_o !== 16'd4) begin miscompares++; $display("[TB] FAIL long_cnt: got %0d, expected 4", frame_cnt_o); end
    vectors++; if (ip_busy_o !== 4'b1111) begin miscompares++; $display("[TB] FAIL long_busy: got %b, expected 1111", ip_busy_o); end
    @(posedge s_aclk);
    #1;
  endtask
`endif

  initial begin
    test_reset();
    test_round_robin();
    test_all_busy();
    test_backpressure();
    test_done_during_stream();
    test_reset_mid_frame();
`ifdef FRAME_BEAT_CHECK_EN
    test_beat_check();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
